fwft_frame_unpacker: RTL and testbench
======================================

Name: fwft_frame_unpacker

Overview:
- Single-clock stage that sits directly downstream of the FWFT FIFO's read side and drains it.
- Input is a length-prefixed word stream: one header word, then the payload words.
- Output is an AXI-Stream master carrying TDATA, TKEEP and TLAST, feeding the TSN MAC/switch datapath.
- Malformed lengths are discarded and flagged, so downstream logic only ever sees well-formed frames.

Parameters:
- C_WIDTH, 32: data word width in bits. Must be a power of 2 and at least 16; bytes per word B = C_WIDTH/8.
- C_LEN_BITS, 16: width of the length field in the header word. Must be less than C_WIDTH.
- C_MAX_LEN, 1518: largest legal frame length in bytes.

Ports:
- CLK  input  1  clock; every signal is in this domain.
- RST  input  1  synchronous reset, active high.
- FIFO_DATA  input  C_WIDTH  FWFT FIFO head word; valid whenever FIFO_EMPTY=0.
- FIFO_EMPTY  input  1  FIFO empty flag.
- FIFO_RD_EN  output  1  pop strobe; combinational.
- M_TDATA  output  C_WIDTH  stream data; registered.
- M_TKEEP  output  B  byte enables; registered.
- M_TVALID  output  1  stream valid.
- M_TLAST  output  1  last beat of the frame.
- M_TREADY  input  1  downstream ready.
- ERR_LEN  output  1  one-cycle pulse when a header carries an illegal length.
- FRAME_CNT  output  32  count of frames delivered.

Behaviour:
- Interface (already decided): one clock, CLK; RST is synchronous and active-high.
- Reset: state returns to IDLE. All outputs are 0: FIFO_RD_EN, M_TDATA, M_TKEEP, M_TVALID, M_TLAST, ERR_LEN, FRAME_CNT. Internal counters are cleared.
- Header format: L = FIFO_DATA[C_LEN_BITS-1:0] is the frame length in bytes. W = (L+B-1)>>log2(B) payload words follow the header.
- Byte order: little-endian; byte 0 is in [7:0].
- FIFO_RD_EN is never asserted while FIFO_EMPTY=1.
- States:
  - IDLE, when FIFO_EMPTY=0:
    - Pop the header; latch L and W into a remaining-word counter.
    - L=0: pulse ERR_LEN next cycle, stay in IDLE.
    - L>C_MAX_LEN: pulse ERR_LEN, go to DROP.
    - Otherwise go to DATA.
  - DATA: pop when FIFO_EMPTY=0 and (M_TVALID=0 or M_TREADY=1). The pop loads, on the next edge:
    - M_TDATA = FIFO_DATA; M_TVALID = 1.
    - M_TLAST = 1 when remaining = 1.
    - M_TKEEP = all ones, except on the last word: the low (L mod B) bits set, or all ones if L mod B = 0.
    - Remaining is decremented. After the last pop, go to IDLE.
  - DROP: pop every cycle FIFO_EMPTY=0, with no stream output, until W words are consumed; then go to IDLE.
- Output register:
  - When M_TVALID=1 and M_TREADY=0, M_TDATA, M_TKEEP and M_TLAST hold stable.
  - When M_TREADY=1 with no new pop, M_TVALID drops to 0 next cycle.
- Latency and throughput:
  - Header-to-first-beat: 2 cycles (header pop cycle, then first payload pop; the beat is visible the cycle after that).
  - Sustained rate is 1 beat/cycle with M_TREADY=1 and the FIFO non-empty.
  - One bubble cycle for each header.
  - IDLE does not pop the next header until the current output beat has been accepted or is the last beat.
  - The next frame's header may be popped in the same cycle the TLAST beat is handed off.
- FRAME_CNT increments on M_TVALID&M_TREADY&M_TLAST and wraps at 2^32.
- FIFO_EMPTY=1 mid-frame: no pop. M_TVALID deasserts after the pending beat is accepted; order is preserved.
- RST mid-frame: the partial frame is abandoned. The next word popped after reset is treated as a header.

Optional Feature:
- Macro: UNPACK_TUSER_EN.
- Defined: an extra output port M_TUSER, width C_WIDTH-C_LEN_BITS.
  - It is latched from FIFO_DATA[C_WIDTH-1:C_LEN_BITS] at header pop.
  - It is presented unchanged on every beat of that frame; reset value 0.
- Not defined: the port does not exist and the header upper bits are ignored.

Test Plan:
All scenarios use C_WIDTH=32, B=4.
1. FIFO holds 0x0000000A, 0x03020100, 0x07060504, 0x00000908; M_TREADY=1 -> 3 beats with TKEEP 1111, 1111, 0011; TLAST on beat 3 only; 4 pops total; FRAME_CNT=1.
2. Header L=8, M_TREADY=0 for 5 cycles after first TVALID -> TDATA=0x03020100 held for 5 cycles; no further pop; after ready, beat 2 arrives with TLAST and TKEEP=1111.
3. Header 0x00000000 followed by a valid L=4 frame -> ERR_LEN high exactly 1 cycle; no TVALID for the bad frame; the next frame is delivered intact.
4. Header L=2000 followed by 500 words, then an L=4 frame -> ERR_LEN pulse; exactly 500 words dropped with M_TVALID=0; the following frame is output correctly.
5. FIFO_EMPTY toggled every other cycle across an L=16 frame -> FIFO_RD_EN never high while empty; 4 beats in order; TVALID gaps allowed.
6. RST asserted after beat 1 of an L=12 frame -> all outputs 0 next cycle, FRAME_CNT=0; the next FIFO word is parsed as a header.

Source files
------------

// File: rtl/fwft_frame_unpacker.sv
// fwft_frame_unpacker: drains a length-prefixed FWFT FIFO word stream into AXI-Stream beats.
// Define UNPACK_TUSER_EN to add M_TUSER, carrying the header's upper bits on every beat of the frame.
module fwft_frame_unpacker #(
    parameter int unsigned C_WIDTH    = 32,
    parameter int unsigned C_LEN_BITS = 16,
    parameter int unsigned C_MAX_LEN  = 1518
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_WIDTH-1:0]            FIFO_DATA,
    input  logic                          FIFO_EMPTY,
    output logic                          FIFO_RD_EN,
    output logic [C_WIDTH-1:0]            M_TDATA,
    output logic [C_WIDTH/8-1:0]          M_TKEEP,
    output logic                          M_TVALID,
    output logic                          M_TLAST,
    input  logic                          M_TREADY,
`ifdef UNPACK_TUSER_EN
    output logic [C_WIDTH-C_LEN_BITS-1:0] M_TUSER,
`endif
    output logic                          ERR_LEN,
    output logic [31:0]                   FRAME_CNT
);

    localparam int unsigned C_BYTES = C_WIDTH / 8;
    localparam int unsigned C_BSH   = $clog2(C_BYTES);
    localparam int unsigned C_CMPW  = (C_LEN_BITS > 32) ? C_LEN_BITS : 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t                r_state;
    logic [C_LEN_BITS-1:0] r_rem;
    logic [C_BSH-1:0]      r_lmod;
    logic [C_WIDTH-1:0]    r_tdata;
    logic [C_BYTES-1:0]    r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_err;
    logic [31:0]           r_frame_cnt;

    logic [C_LEN_BITS-1:0] w_len;
    logic [C_LEN_BITS:0]   w_sum;
    logic [C_LEN_BITS-1:0] w_words;
    logic                  w_len_zero;
    logic                  w_len_big;
    logic                  w_out_free;
    logic                  w_pop;
    logic                  w_last;
    logic [C_BYTES-1:0]    w_keep_last;

`ifdef UNPACK_TUSER_EN
    logic [C_WIDTH-C_LEN_BITS-1:0] r_user_hdr;
    logic [C_WIDTH-C_LEN_BITS-1:0] r_tuser;
    assign M_TUSER = r_tuser;
`else
    logic w_unused_hdr;
    assign w_unused_hdr = ^FIFO_DATA[C_WIDTH-1:C_LEN_BITS];
`endif

    assign w_len      = FIFO_DATA[C_LEN_BITS-1:0];
    assign w_sum      = {1'b0, w_len} + (C_LEN_BITS+1)'(C_BYTES - 1);
    assign w_words    = C_LEN_BITS'(w_sum >> C_BSH);
    assign w_len_zero = (w_len == '0);
    assign w_len_big  = C_CMPW'(w_len) > C_CMPW'(C_MAX_LEN);
    assign w_out_free = !r_tvalid || M_TREADY;
    assign w_last     = (r_rem == C_LEN_BITS'(1));

    // A pending TLAST beat does not block the next header; DATA waits for it instead.
    always_comb begin
        w_pop = 1'b0;
        if (!RST && !FIFO_EMPTY) begin
            case (r_state)
                S_IDLE:  w_pop = w_out_free || r_tlast;
                S_DATA:  w_pop = w_out_free;
                S_DROP:  w_pop = 1'b1;
                default: w_pop = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_keep_last = '1;
        for (int unsigned i = 0; i < C_BYTES; i++) begin
            if (r_lmod != '0 && C_BSH'(i) >= r_lmod) begin
                w_keep_last[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_lmod      <= '0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
`ifdef UNPACK_TUSER_EN
            r_user_hdr  <= '0;
            r_tuser     <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            if (r_tvalid && M_TREADY) begin
                r_tvalid <= 1'b0;
                if (r_tlast) begin
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_rem  <= w_words;
                        r_lmod <= w_len[C_BSH-1:0];
`ifdef UNPACK_TUSER_EN
                        r_user_hdr <= FIFO_DATA[C_WIDTH-1:C_LEN_BITS];
`endif
                        if (w_len_zero) begin
                            r_err <= 1'b1;
                        end else if (w_len_big) begin
                            r_err   <= 1'b1;
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_pop) begin
                        r_tdata  <= FIFO_DATA;
                        r_tvalid <= 1'b1;
                        r_tlast  <= w_last;
                        r_tkeep  <= w_last ? w_keep_last : '1;
                        r_rem    <= r_rem - C_LEN_BITS'(1);
`ifdef UNPACK_TUSER_EN
                        r_tuser  <= r_user_hdr;
`endif
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (w_pop) begin
                        r_rem <= r_rem - C_LEN_BITS'(1);
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign FIFO_RD_EN = w_pop;
    assign M_TDATA    = r_tdata;
    assign M_TKEEP    = r_tkeep;
    assign M_TVALID   = r_tvalid;
    assign M_TLAST    = r_tlast;
    assign ERR_LEN    = r_err;
    assign FRAME_CNT  = r_frame_cnt;

endmodule

// File: tb/tb_fwft_frame_unpacker.sv
// Bench for fwft_frame_unpacker: FIFO model plus expected-beat scoreboard, table of frame vectors
// and hand sequences for output stall and mid-frame reset.
`timescale 1ns/1ps
module tb_fwft_frame_unpacker;

    localparam int unsigned MAXL = 1518;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] FIFO_DATA;
    logic        FIFO_EMPTY;
    logic        FIFO_RD_EN;
    logic [31:0] M_TDATA;
    logic [3:0]  M_TKEEP;
    logic        M_TVALID;
    logic        M_TLAST;
    logic        M_TREADY;
    logic        ERR_LEN;
    logic [31:0] FRAME_CNT;
`ifdef UNPACK_TUSER_EN
    logic [15:0] M_TUSER;
`endif

    fwft_frame_unpacker #(
        .C_WIDTH   (32),
        .C_LEN_BITS(16),
        .C_MAX_LEN (MAXL)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FIFO_DATA (FIFO_DATA),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RD_EN(FIFO_RD_EN),
        .M_TDATA   (M_TDATA),
        .M_TKEEP   (M_TKEEP),
        .M_TVALID  (M_TVALID),
        .M_TLAST   (M_TLAST),
        .M_TREADY  (M_TREADY),
`ifdef UNPACK_TUSER_EN
        .M_TUSER   (M_TUSER),
`endif
        .ERR_LEN   (ERR_LEN),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [15:0] user;
    } beat_t;

    typedef struct {
        int unsigned len;
        logic [15:0] user;
        bit          rnd;
        bit          tog;
        int unsigned beats;
        int unsigned errs;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] fifo_q[$];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;
    bit          toggle_mode = 1'b0;
    bit          rand_ready = 1'b0;
    int unsigned n_hs = 0;
    int unsigned n_err = 0;
    int          t_first_pop = -1;
    int          t_last = -1;
    int unsigned exp_frames = 0;
    logic        prev_err = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_keep = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic update_inputs();
        FIFO_EMPTY = (fifo_q.size() == 0) || (toggle_mode && (cyc % 2 == 1));
        FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        if (rand_ready) M_TREADY = 1'($urandom_range(0, 1));
    endtask

    task automatic push_frame(input int unsigned len, input logic [15:0] user, input logic [7:0] seed);
        int unsigned nw;
        bit          legal;
        nw    = (len + 3) / 4;
        legal = (len != 0) && (len <= MAXL);
        fifo_q.push_back({user, 16'(len)});
        for (int unsigned j = 0; j < nw; j++) begin
            logic [31:0] w;
            beat_t       e;
            w = '0;
            for (int unsigned b = 0; b < 4; b++) begin
                if (4 * j + b < len) w[8*b +: 8] = 8'(4 * j + b) + seed;
            end
            fifo_q.push_back(w);
            if (legal) begin
                e.data = w;
                e.last = (j == nw - 1);
                e.keep = (e.last && (len % 4 != 0)) ? 4'((1 << (len % 4)) - 1) : 4'hF;
                e.user = user;
                exp_q.push_back(e);
            end
        end
        update_inputs();
    endtask

    // Observe at the falling edge what the next rising edge will do, then apply pops after it.
    task automatic tick();
        logic  rd;
        beat_t e;
        @(negedge CLK);
        rd = FIFO_RD_EN;
        if (FIFO_EMPTY) chk("rd_while_empty", 64'(rd), 0);
        if (ERR_LEN) begin
            chk("err_pulse_width", 64'(prev_err), 0);
            n_err++;
        end
        prev_err = ERR_LEN;
        if (prev_stall) begin
            chk("hold_valid", 64'(M_TVALID), 1);
            chk("hold_data", 64'(M_TDATA), 64'(prev_data));
            chk("hold_keep", 64'(M_TKEEP), 64'(prev_keep));
            chk("hold_last", 64'(M_TLAST), 64'(prev_last));
        end
        prev_stall = M_TVALID && !M_TREADY && !RST;
        prev_data  = M_TDATA;
        prev_keep  = M_TKEEP;
        prev_last  = M_TLAST;
        if (M_TVALID && M_TREADY && !RST) begin
            n_hs++;
            chk("beat_queued", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 64'(M_TDATA), 64'(e.data));
                chk("beat_keep", 64'(M_TKEEP), 64'(e.keep));
                chk("beat_last", 64'(M_TLAST), 64'(e.last));
`ifdef UNPACK_TUSER_EN
                chk("beat_user", 64'(M_TUSER), 64'(e.user));
`endif
                if (e.last && t_last < 0) t_last = cyc;
            end
        end
        if (rd && t_first_pop < 0) t_first_pop = cyc;
        @(posedge CLK);
        #1;
        if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        cyc++;
        update_inputs();
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || M_TVALID) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 64'(n < budget), 1);
        tick();
        tick();
    endtask

    vec_t vt[10];

    initial begin
        int unsigned k;
        vt[0] = '{10,   16'h0000, 1'b0, 1'b0,   4, 0};
        vt[1] = '{0,    16'h1234, 1'b0, 1'b0,   1, 1};
        vt[2] = '{2000, 16'h5A5A, 1'b0, 1'b0,   1, 1};
        vt[3] = '{16,   16'hA5A5, 1'b0, 1'b1,   5, 0};
        vt[4] = '{1518, 16'h0F0F, 1'b0, 1'b0, 381, 0};
        vt[5] = '{1519, 16'hF00D, 1'b0, 1'b0,   1, 1};
        vt[6] = '{1,    16'h0001, 1'b0, 1'b0,   2, 0};
        vt[7] = '{7,    16'hC0DE, 1'b1, 1'b0,   3, 0};
        vt[8] = '{64,   16'hFFFF, 1'b1, 1'b1,  17, 0};
        vt[9] = '{4,    16'h8000, 1'b0, 1'b0,   2, 0};

        RST = 1'b1;
        M_TREADY = 1'b0;
        update_inputs();
        tick();
        tick();
        chk("rst_rd_en", 64'(FIFO_RD_EN), 0);
        chk("rst_tdata", 64'(M_TDATA), 0);
        chk("rst_tkeep", 64'(M_TKEEP), 0);
        chk("rst_tvalid", 64'(M_TVALID), 0);
        chk("rst_tlast", 64'(M_TLAST), 0);
        chk("rst_err", 64'(ERR_LEN), 0);
        chk("rst_frame_cnt", 64'(FRAME_CNT), 0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            rand_ready  = vt[i].rnd;
            toggle_mode = vt[i].tog;
            M_TREADY    = 1'b1;
            n_hs        = 0;
            n_err       = 0;
            t_first_pop = -1;
            t_last      = -1;
            push_frame(vt[i].len, vt[i].user, 8'(i * 16));
            push_frame(4, 16'h4B1D, 8'hC0);
            drain(4000);
            chk("vec_beats", 64'(n_hs), 64'(vt[i].beats));
            chk("vec_errs", 64'(n_err), 64'(vt[i].errs));
            exp_frames += (vt[i].errs != 0) ? 1 : 2;
            chk("vec_frame_cnt", 64'(FRAME_CNT), 64'(exp_frames));
            if (!vt[i].rnd && !vt[i].tog && vt[i].errs == 0)
                chk("vec_latency", 64'(t_last - t_first_pop), 64'((vt[i].len + 3) / 4 + 1));
        end

        // Downstream stall on the first beat of an 8-byte frame.
        rand_ready  = 1'b0;
        toggle_mode = 1'b0;
        M_TREADY    = 1'b0;
        n_hs        = 0;
        push_frame(8, 16'h00AA, 8'h00);
        k = 0;
        while (!M_TVALID && k < 20) begin
            tick();
            k++;
        end
        chk("stall_valid_seen", 64'(M_TVALID), 1);
        for (int s = 0; s < 5; s++) begin
            chk("stall_data", 64'(M_TDATA), 64'h03020100);
            chk("stall_no_pop", 64'(FIFO_RD_EN), 0);
            tick();
        end
        M_TREADY = 1'b1;
        drain(100);
        chk("stall_beats", 64'(n_hs), 2);
        exp_frames++;
        chk("stall_frame_cnt", 64'(FRAME_CNT), 64'(exp_frames));

        // Reset after the first beat of a 12-byte frame.
        n_hs = 0;
        push_frame(12, 16'h0C0C, 8'h40);
        k = 0;
        while (n_hs == 0 && k < 20) begin
            tick();
            k++;
        end
        chk("mid_rst_beat1", 64'(n_hs), 1);
        RST = 1'b1;
        M_TREADY = 1'b0;
        tick();
        chk("mid_rst_rd_en", 64'(FIFO_RD_EN), 0);
        chk("mid_rst_tdata", 64'(M_TDATA), 0);
        chk("mid_rst_tkeep", 64'(M_TKEEP), 0);
        chk("mid_rst_tvalid", 64'(M_TVALID), 0);
        chk("mid_rst_tlast", 64'(M_TLAST), 0);
        chk("mid_rst_err", 64'(ERR_LEN), 0);
        chk("mid_rst_frame_cnt", 64'(FRAME_CNT), 0);
        RST = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        exp_frames = 0;
        M_TREADY = 1'b1;
        n_hs = 0;
        push_frame(4, 16'h4444, 8'h80);
        drain(100);
        chk("post_rst_beats", 64'(n_hs), 1);
        chk("post_rst_frame_cnt", 64'(FRAME_CNT), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
